pn_shift_scheduler: RTL

//  Shares the pipelined PN96 permutation network (columns of 2x2 SwitchUnit cells) between NREQ requesters.
//  - Arbitrates shift requests round-robin.
//  - Issues each granted burst of data beats.
//  - Drives the per-stage ctrl bits, staggered so they line up with each beat as it moves through
//    the registered stages.

---
 rtl/pn_shift_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pn_shift_scheduler.sv
// Round-robin shift scheduler for the pipelined PN96 permutation network: grants bursts, issues beats
// and drives staggered per-stage ctrl bits. Optional shift range check: define PN_SHIFT_CHECK_EN.
module pn_shift_scheduler #(
  parameter int NREQ = 2,
  parameter int SW   = 7,
  parameter int Z    = 96,
  parameter int LW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*SW-1:0]       req_shift,
  input  logic [NREQ*LW-1:0]       req_len,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          beat_en,
  output logic [SW-1:0]            stage_ctrl,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic                     busy,
  output logic                     err
);
  localparam int IDW = $clog2(NREQ);
`ifdef PN_SHIFT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic             err_q, err_d;

  // Pipeline stage k (1..SW) holds the beat issued k cycles ago; stage 0 is the issuing beat itself.
  logic [SW:1]      pv_q, pv_d;
  logic [SW:1]      pl_q, pl_d;
  logic [SW-1:0]    ps_q [1:SW];
  logic [SW-1:0]    ps_d [1:SW];
  logic [IDW-1:0]   pid_q [1:SW];
  logic [IDW-1:0]   pid_d [1:SW];

  logic             win_found_s, window_s, accept_s, issue_s, last_s, bad_s;
  logic [IDW-1:0]   win_id_s;
  logic [SW-1:0]    sel_shift_s;
  logic [LW-1:0]    sel_len_s;
  int               arb_idx;

  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {IDW{1'b0}};
    arb_idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      arb_idx = (int'(rr_q) + i) % NREQ;
      if (!win_found_s && req_valid[arb_idx]) begin
        win_found_s = 1'b1;
        win_id_s    = IDW'(arb_idx);
      end
    end
    issue_s     = (state_q == RUN);
    last_s      = (cnt_q == LW'(1));
    window_s    = (state_q == IDLE) || (issue_s && last_s);
    accept_s    = window_s && win_found_s && !rst;
    sel_shift_s = req_shift[win_id_s*SW +: SW];
    sel_len_s   = req_len[win_id_s*LW +: LW];
    bad_s       = CHECK_EN && (32'(sel_shift_s) >= 32'(Z));
    req_ack     = accept_s ? (NREQ'(1) << win_id_s) : {NREQ{1'b0}};
    beat_en     = issue_s ? (NREQ'(1) << id_q) : {NREQ{1'b0}};
  end

  // A rejected or zero-length request still takes the RR turn but leaves the FSM idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    id_d    = id_q;
    rr_d    = rr_q;
    err_d   = 1'b0;
    if (issue_s) begin
      cnt_d = cnt_q - LW'(1);
      if (last_s) state_d = IDLE;
    end
    if (accept_s) begin
      rr_d    = (int'(win_id_s) == NREQ - 1) ? {IDW{1'b0}} : win_id_s + IDW'(1);
      shift_d = sel_shift_s;
      id_d    = win_id_s;
      err_d   = bad_s;
      if (!bad_s && (sel_len_s != {LW{1'b0}})) begin
        state_d = RUN;
        cnt_d   = sel_len_s;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    pv_d[1]  = issue_s;
    pl_d[1]  = last_s;
    ps_d[1]  = shift_q;
    pid_d[1] = id_q;
    for (int k = 2; k <= SW; k++) begin
      pv_d[k]  = pv_q[k-1];
      pl_d[k]  = pl_q[k-1];
      ps_d[k]  = ps_q[k-1];
      pid_d[k] = pid_q[k-1];
    end
    stage_ctrl    = {SW{1'b0}};
    stage_ctrl[0] = issue_s & shift_q[0];
    for (int k = 1; k < SW; k++) begin
      stage_ctrl[k] = pv_q[k] & ps_q[k][k];
    end
  end

  assign out_valid = pv_q[SW];
  assign out_last  = pv_q[SW] & pl_q[SW];
  assign out_id    = pv_q[SW] ? pid_q[SW] : {IDW{1'b0}};
  assign busy      = issue_s | (|pv_q);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {LW{1'b0}};
      shift_q <= {SW{1'b0}};
      id_q    <= {IDW{1'b0}};
      rr_q    <= {IDW{1'b0}};
      err_q   <= 1'b0;
      pv_q    <= {SW{1'b0}};
      pl_q    <= {SW{1'b0}};
      for (int k = 1; k <= SW; k++) begin
        ps_q[k]  <= {SW{1'b0}};
        pid_q[k] <= {IDW{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      for (int k = 1; k <= SW; k++) begin
        ps_q[k]  <= ps_d[k];
        pid_q[k] <= pid_d[k];
      end
    end
  end
endmodule
